// File: rtl/if_fetch_ctrl.sv
// Instruction fetch sequencer feeding the IF/ID pipeline register.
// Owns the PC and issues req/ack fetches to a variable-latency memory. It inserts NOP bubbles
// while memory is slow and parks a word in a one-entry skid while the hazard unit stalls.
// Taken branches redirect the PC and flush IF/ID.
// Optional feature macro: FETCH_TIMEOUT_EN (request timeout -> sticky fetch_err, ERR state).
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        stall_in,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_flush,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    StReq,
    StHold,
    StDiscard
`ifdef FETCH_TIMEOUT_EN
    , StErr
`endif
  } state_t;

  state_t      r_state,      w_state_nxt;
  logic [31:0] r_pc,         w_pc_nxt;
  logic [31:0] r_disc_addr,  w_disc_addr_nxt;
  logic        r_skid_vld,   w_skid_vld_nxt;
  logic [31:0] r_skid_pc,    w_skid_pc_nxt;
  logic [31:0] r_skid_instr, w_skid_instr_nxt;
  logic [31:0] r_if_pc,      w_if_pc_nxt;
  logic [31:0] r_if_instr,   w_if_instr_nxt;
  logic [31:0] w_pc_inc;

  assign w_pc_inc = r_pc + 32'd4;

`ifdef FETCH_TIMEOUT_EN
  logic [7:0] r_wait_cnt,  w_wait_cnt_nxt;
  logic       r_fetch_err, w_fetch_err_nxt;
`else
  // MAX_WAIT only has meaning when the timeout logic is built.
  logic w_unused_cfg;
  assign w_unused_cfg = ^MAX_WAIT;
`endif

  // Next-state, PC, skid and IF/ID output selection.
  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_disc_addr_nxt  = r_disc_addr;
    w_skid_vld_nxt   = r_skid_vld;
    w_skid_pc_nxt    = r_skid_pc;
    w_skid_instr_nxt = r_skid_instr;
    w_if_pc_nxt      = r_if_pc;
    w_if_instr_nxt   = r_if_instr;

    unique case (r_state)
      StReq: begin
        if (br_taken) begin
          // The in-flight request must finish at its old address; drop its word later.
          w_pc_nxt        = br_target;
          w_disc_addr_nxt = r_pc;
          w_state_nxt     = mem_ack ? StReq : StDiscard;
        end else if (mem_ack) begin
          w_pc_nxt = w_pc_inc;
          if (stall_in) begin
            w_skid_vld_nxt   = 1'b1;
            w_skid_pc_nxt    = w_pc_inc;
            w_skid_instr_nxt = mem_rdata;
            w_state_nxt      = StHold;
          end
        end
      end
      StHold: begin
        if (br_taken) begin
          w_skid_vld_nxt = 1'b0;
          w_pc_nxt       = br_target;
          w_state_nxt    = StReq;
        end else if (!stall_in) begin
          w_skid_vld_nxt = 1'b0;
          w_state_nxt    = StReq;
        end
      end
      StDiscard: begin
        if (br_taken) w_pc_nxt = br_target;
        if (mem_ack) w_state_nxt = StReq;
      end
`ifdef FETCH_TIMEOUT_EN
      StErr: ;
`endif
      default: w_state_nxt = StReq;
    endcase

    // IF/ID payload: flush beats stall, stall beats skid drain, then fresh word, else bubble.
    if (br_taken) begin
      w_if_pc_nxt    = 32'h0;
      w_if_instr_nxt = 32'h0;
    end else if (stall_in) begin
      w_if_pc_nxt    = r_if_pc;
      w_if_instr_nxt = r_if_instr;
    end else if (r_skid_vld) begin
      w_if_pc_nxt    = r_skid_pc;
      w_if_instr_nxt = r_skid_instr;
    end else if (r_state == StReq && mem_ack) begin
      w_if_pc_nxt    = w_pc_inc;
      w_if_instr_nxt = mem_rdata;
    end else begin
      w_if_pc_nxt    = 32'h0;
      w_if_instr_nxt = 32'h0;
    end

`ifdef FETCH_TIMEOUT_EN
    w_wait_cnt_nxt  = r_wait_cnt;
    w_fetch_err_nxt = r_fetch_err;
    if (r_state == StReq || r_state == StDiscard) begin
      // Any ack or state change (including branch into DISCARD) restarts the wait.
      if (mem_ack || w_state_nxt != r_state) begin
        w_wait_cnt_nxt = 8'd0;
      end else if (r_wait_cnt == 8'(MAX_WAIT)) begin
        w_state_nxt     = StErr;
        w_fetch_err_nxt = 1'b1;
      end else begin
        w_wait_cnt_nxt = r_wait_cnt + 8'd1;
      end
    end else begin
      w_wait_cnt_nxt = 8'd0;
    end
    if (r_state == StErr) begin
      w_if_pc_nxt    = 32'h0;
      w_if_instr_nxt = 32'h0;
    end
`endif
  end

  // State, PC, skid and IF/ID payload registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= StReq;
      r_pc         <= RESET_PC;
      r_disc_addr  <= 32'h0;
      r_skid_vld   <= 1'b0;
      r_skid_pc    <= 32'h0;
      r_skid_instr <= 32'h0;
      r_if_pc      <= 32'h0;
      r_if_instr   <= 32'h0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_disc_addr  <= w_disc_addr_nxt;
      r_skid_vld   <= w_skid_vld_nxt;
      r_skid_pc    <= w_skid_pc_nxt;
      r_skid_instr <= w_skid_instr_nxt;
      r_if_pc      <= w_if_pc_nxt;
      r_if_instr   <= w_if_instr_nxt;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  // Wait counter and sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt  <= 8'd0;
      r_fetch_err <= 1'b0;
    end else begin
      r_wait_cnt  <= w_wait_cnt_nxt;
      r_fetch_err <= w_fetch_err_nxt;
    end
  end
  assign fetch_err = r_fetch_err;
`else
  assign fetch_err = 1'b0;
`endif

  // Request is gated by rst so it drops immediately on an asynchronous reset.
  assign mem_req  = !rst && (r_state == StReq || r_state == StDiscard);
  assign mem_addr = (r_state == StDiscard) ? r_disc_addr : r_pc;
  assign if_pc    = r_if_pc;
  assign if_instr = r_if_instr;
  assign if_flush = br_taken;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Self-checking bench for if_fetch_ctrl (default build). Expected delivered words are queued
// when the bench acks a fetch that should survive, and popped when IF/ID presents a new word.
module tb_if_fetch_ctrl;

  localparam logic [31:0] Key = 32'hA5A5A5A5;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        stall_in;
  logic        br_taken;
  logic [31:0] br_target;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_flush;
  logic        fetch_err;

  int n_chk = 0;
  int n_err = 0;
  logic [63:0] sb_q[$];

  if_fetch_ctrl #(
    .RESET_PC (32'h0),
    .MAX_WAIT (15)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .stall_in  (stall_in),
    .br_taken  (br_taken),
    .br_target (br_target),
    .if_pc     (if_pc),
    .if_instr  (if_instr),
    .if_flush  (if_flush),
    .fetch_err (fetch_err)
  );

  always #5 clk = ~clk;

  // Memory returns a word derived from its address.
  assign mem_rdata = mem_addr ^ Key;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] a);
    logic [31:0] npc;
    npc = a + 32'd4;
    sb_q.push_back({npc, a ^ Key});
  endtask

  // Monitor: every newly presented non-bubble word must be the next one expected.
  always begin : mon
    logic [63:0] e;
    logic [31:0] prev_pc;
    logic [31:0] prev_instr;
    prev_pc    = 32'h0;
    prev_instr = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && (if_pc !== prev_pc || if_instr !== prev_instr) && if_instr != 32'h0) begin
        if (sb_q.size() == 0) begin
          check_eq("unexpected_word", if_instr, 32'h0);
        end else begin
          e = sb_q.pop_front();
          check_eq("word_pc", if_pc, e[63:32]);
          check_eq("word_instr", if_instr, e[31:0]);
        end
      end
      prev_pc    = if_pc;
      prev_instr = if_instr;
    end
  end

  initial begin
    rst       = 1'b1;
    mem_ack   = 1'b0;
    stall_in  = 1'b0;
    br_taken  = 1'b0;
    br_target = 32'h0;
    #12;
    check_eq("rst_mem_req", mem_req, 1'b0);
    check_eq("rst_if_pc", if_pc, 32'h0);
    check_eq("rst_if_instr", if_instr, 32'h0);
    check_eq("rst_fetch_err", fetch_err, 1'b0);
    check_eq("rst_if_flush", if_flush, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("first_req", mem_req, 1'b1);

    // Back-to-back with ack tied high.
    mem_ack = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check_eq("b2b_addr", mem_addr, 32'(4 * i));
      push_word(32'(4 * i));
      tick();
    end
    mem_ack = 1'b0;
    tick();
    check_eq("idle_bubble", if_instr, 32'h0);

    // Slow memory: two un-acked cycles per word.
    for (int w = 0; w < 2; w++) begin
      for (int k = 0; k < 2; k++) begin
        check_eq("wait_req", mem_req, 1'b1);
        check_eq("wait_addr", mem_addr, 32'(24 + 4 * w));
        tick();
        check_eq("wait_bubble", if_instr, 32'h0);
      end
      mem_ack = 1'b1;
      push_word(32'(24 + 4 * w));
      tick();
      mem_ack = 1'b0;
    end

    // Stall as the ack for 32 arrives: hold old word, park new word in skid.
    check_eq("stall_addr", mem_addr, 32'd32);
    mem_ack  = 1'b1;
    stall_in = 1'b1;
    push_word(32'd32);
    tick();
    mem_ack = 1'b0;
    for (int k = 0; k < 2; k++) begin
      check_eq("hold_pc", if_pc, 32'd32);
      check_eq("hold_instr", if_instr, 32'd28 ^ Key);
      check_eq("hold_req", mem_req, 1'b0);
      if (k == 1) stall_in = 1'b0;
      tick();
    end
    check_eq("release_pc", if_pc, 32'd36);
    check_eq("release_addr", mem_addr, 32'd36);

    // Branch with request pending: old address held, its word dropped.
    br_taken  = 1'b1;
    br_target = 32'h100;
    #1;
    check_eq("flush_comb", if_flush, 1'b1);
    tick();
    br_taken = 1'b0;
    check_eq("flush_bubble", if_instr, 32'h0);
    check_eq("discard_req", mem_req, 1'b1);
    check_eq("discard_addr", mem_addr, 32'd36);
    tick();
    check_eq("discard_addr2", mem_addr, 32'd36);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check_eq("dropped_word", if_instr, 32'h0);
    check_eq("redirect_addr", mem_addr, 32'h100);
    mem_ack = 1'b1;
    push_word(32'h100);
    tick();
    mem_ack = 1'b0;
    check_eq("flush_low", if_flush, 1'b0);

    // Branch in the same cycle as ack: word dropped, new address immediately.
    mem_ack   = 1'b1;
    br_taken  = 1'b1;
    br_target = 32'h200;
    tick();
    br_taken = 1'b0;
    mem_ack  = 1'b0;
    check_eq("br_ack_bubble", if_instr, 32'h0);
    check_eq("br_ack_addr", mem_addr, 32'h200);
    mem_ack = 1'b1;
    push_word(32'h200);
    tick();

    // Branch plus stall while holding: skid word must never appear.
    stall_in = 1'b1;
    tick();
    mem_ack = 1'b0;
    check_eq("hold2_req", mem_req, 1'b0);
    check_eq("hold2_pc", if_pc, 32'h204);
    br_taken  = 1'b1;
    br_target = 32'h300;
    tick();
    br_taken = 1'b0;
    stall_in = 1'b0;
    check_eq("br_hold_pc", if_pc, 32'h0);
    check_eq("br_hold_instr", if_instr, 32'h0);
    check_eq("br_hold_req", mem_req, 1'b1);
    check_eq("br_hold_addr", mem_addr, 32'h300);
    mem_ack = 1'b1;
    push_word(32'h300);
    tick();

    // PC wrap at the top of the address space.
    br_taken  = 1'b1;
    br_target = 32'hFFFF_FFFC;
    tick();
    br_taken = 1'b0;
    check_eq("top_addr", mem_addr, 32'hFFFF_FFFC);
    push_word(32'hFFFF_FFFC);
    tick();
    mem_ack = 1'b0;
    check_eq("wrap_addr", mem_addr, 32'h0);
    check_eq("wrap_pc", if_pc, 32'h0);

    // Unaligned target passes through; discard keeps the old address meanwhile.
    br_taken  = 1'b1;
    br_target = 32'h402;
    tick();
    br_taken = 1'b0;
    check_eq("frozen_addr", mem_addr, 32'h0);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check_eq("unaligned_addr", mem_addr, 32'h402);

    // Reset mid-fetch: request drops at once, acks during reset are ignored.
    rst = 1'b1;
    #1;
    check_eq("async_req_drop", mem_req, 1'b0);
    check_eq("async_if_pc", if_pc, 32'h0);
    mem_ack = 1'b1;
    tick();
    tick();
    mem_ack = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("post_rst_req", mem_req, 1'b1);
    check_eq("post_rst_addr", mem_addr, 32'h0);
    tick();
    check_eq("post_rst_bubble", if_instr, 32'h0);
    mem_ack = 1'b1;
    push_word(32'h0);
    tick();
    mem_ack = 1'b0;
    tick();

    check_eq("sb_leftover", sb_q.size(), 32'd0);
    check_eq("end_fetch_err", fetch_err, 1'b0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
